// File: rtl/multichannel_sample_to_pixel_addr_translator_pkg.sv
// ---------------------------------------------------------------------------
// viz_pkg
// Shared definitions for the multichannel sample-to-pixel address translator:
//   - state_t        : translator FSM states
//   - FB_* constants : default framebuffer geometry
//   - clamp_row()    : clamp a computed row index into a lane
// Optional feature macro used by the files that import this package:
//   CLIP_DETECT_EN
// ---------------------------------------------------------------------------
package viz_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        SCALE   = 3'd3,
        ADDR    = 3'd4,
        EMIT    = 3'd5
    } state_t;

    localparam int FB_LANE_ROWS      = 288;
    localparam int FB_WORDS_PER_ROW  = 24;
    localparam int FB_ADDRESS_LENGTH = 14;

    // Clamp a row index into [0, rows-1].
    function automatic int clamp_row(input int r, input int rows);
        if (r < 0) begin
            return 0;
        end else if (r > rows - 1) begin
            return rows - 1;
        end else begin
            return r;
        end
    endfunction

endpackage

// File: rtl/multichannel_sample_to_pixel_addr_translator_if.sv
// ---------------------------------------------------------------------------
// multichannel_sample_to_pixel_addr_translator_if
// Pixel-address output channel from the translator to the framebuffer
// pixel-set writer.
//   word_address : framebuffer word address
//   bit_offset   : bit within the 32-bit word
//   channel      : channel index of the current output
//   clip_flag    : sample clamped / near full scale (only with CLIP_DETECT_EN)
//   out_valid    : payload valid
//   out_ready    : consumer can accept
// Handshake: a transfer happens on a rising clk edge where out_valid and
// out_ready are both high. Once out_valid is raised, it and every payload
// field stay stable until that transfer; out_valid never waits on out_ready.
// Modports: master = translator, slave = consumer.
// ---------------------------------------------------------------------------
interface multichannel_sample_to_pixel_addr_translator_if #(
    parameter int ADDRESS_LENGTH = 14,
    parameter int CH_W           = 1
);
    logic [ADDRESS_LENGTH-1:0] word_address;
    logic [4:0]                bit_offset;
    logic [CH_W-1:0]           channel;
    logic                      out_valid;
    logic                      out_ready;
`ifdef CLIP_DETECT_EN
    logic                      clip_flag;
`endif

    modport master (
`ifdef CLIP_DETECT_EN
        output clip_flag,
`endif
        output word_address,
        output bit_offset,
        output channel,
        output out_valid,
        input  out_ready
    );

    modport slave (
`ifdef CLIP_DETECT_EN
        input  clip_flag,
`endif
        input  word_address,
        input  bit_offset,
        input  channel,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/multichannel_sample_to_pixel_addr_translator_sample_row_mapper.sv
// ---------------------------------------------------------------------------
// sample_row_mapper
// Maps a signed sample to a row inside a channel lane.
//   row = LANE_ROWS/2 - ((s * LANE_ROWS/2) >>> (SAMPLE_BITS-1)), clamped.
// Ports:
//   clk, reset   : clock, async active-high reset
//   load         : capture sample_in / ch_in this cycle
//   sample_in    : signed sample (SAMPLE_BITS)
//   ch_in        : channel index travelling with the sample
//   row_out      : clamped row, valid two cycles after load
//   clipped_out  : row clamped or sample near full scale (CLIP_DETECT_EN only)
//   ch_out       : registered channel index
// Optional feature macro: CLIP_DETECT_EN
// ---------------------------------------------------------------------------
module sample_row_mapper
    import viz_pkg::*;
#(
    parameter int SAMPLE_BITS = 24,
    parameter int LANE_ROWS   = FB_LANE_ROWS,
    parameter int CH_W        = 1,
    parameter int ROW_W       = $clog2(LANE_ROWS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [SAMPLE_BITS-1:0] sample_in,
    input  logic [CH_W-1:0]        ch_in,
    output logic [ROW_W-1:0]       row_out,
`ifdef CLIP_DETECT_EN
    output logic                   clipped_out,
`endif
    output logic [CH_W-1:0]        ch_out
);
    // Product width keeps the full signed precision of s * (LANE_ROWS/2).
    localparam int P_W = SAMPLE_BITS + 10;
    localparam logic signed [P_W-1:0] HALF_ROWS = P_W'(LANE_ROWS / 2);

    logic [SAMPLE_BITS-1:0] s_q, s_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic signed [P_W-1:0]  s_ext;
    logic signed [P_W-1:0]  prod;
    logic signed [P_W-1:0]  row_full;
    int                     row_int;
    int                     row_clamped;

`ifdef CLIP_DETECT_EN
    // Within 1/8 of full scale counts as clipping.
    localparam int CLIP_THR = (1 << (SAMPLE_BITS - 1)) - (1 << (SAMPLE_BITS - 4));
    localparam logic signed [P_W-1:0] CLIP_POS = P_W'(CLIP_THR);
    localparam logic signed [P_W-1:0] CLIP_NEG = -CLIP_POS;
    logic clipped_q, clipped_d;
`endif

    always_comb begin
        s_d  = load ? sample_in : s_q;
        ch_d = load ? ch_in : ch_q;

        s_ext       = {{(P_W - SAMPLE_BITS){s_q[SAMPLE_BITS-1]}}, s_q};
        prod        = s_ext * HALF_ROWS;
        // Arithmetic shift floors toward -inf, so full-scale negative lands
        // one row past the lane and is caught by the clamp.
        row_full    = HALF_ROWS - (prod >>> (SAMPLE_BITS - 1));
        row_int     = int'(row_full);
        row_clamped = clamp_row(row_int, LANE_ROWS);
        row_d       = ROW_W'(row_clamped);
`ifdef CLIP_DETECT_EN
        clipped_d   = (row_clamped != row_int) || (s_ext >= CLIP_POS) || (s_ext <= CLIP_NEG);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q       <= '0;
            ch_q      <= '0;
            row_q     <= '0;
`ifdef CLIP_DETECT_EN
            clipped_q <= 1'b0;
`endif
        end else begin
            s_q       <= s_d;
            ch_q      <= ch_d;
            row_q     <= row_d;
`ifdef CLIP_DETECT_EN
            clipped_q <= clipped_d;
`endif
        end
    end

    assign row_out = row_q;
    assign ch_out  = ch_q;
`ifdef CLIP_DETECT_EN
    assign clipped_out = clipped_q;
`endif

endmodule

// File: rtl/multichannel_sample_to_pixel_addr_translator.sv
// ---------------------------------------------------------------------------
// multichannel_sample_to_pixel_addr_translator
// Pops interleaved NUM_CH-channel frames from the audio sample FIFO and turns
// each sample into a one-bit-per-pixel framebuffer location inside that
// channel's lane. One column per frame; VSYNC resets the column at the end
// of the frame in progress.
// Ports:
//   clk, reset         : clock, async active-high reset
//   fifo_dout          : FIFO read data (valid the cycle after fifo_rd_en)
//   fifo_almost_empty  : low when a whole frame is available
//   vsync_pulse        : start-of-frame strobe
//   fifo_rd_en         : one-cycle FIFO pop
//   pix (master)       : word_address / bit_offset / channel / out_valid /
//                        out_ready (+ clip_flag with CLIP_DETECT_EN)
//   dbg_state          : current FSM state
// Optional feature macro: CLIP_DETECT_EN
// ---------------------------------------------------------------------------
module multichannel_sample_to_pixel_addr_translator
    import viz_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int SAMPLE_BITS    = 24,
    parameter int ADDRESS_LENGTH = FB_ADDRESS_LENGTH,
    parameter int NUM_CH         = 2,
    parameter int LANE_ROWS      = FB_LANE_ROWS,
    parameter int WORDS_PER_ROW  = FB_WORDS_PER_ROW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_almost_empty,
    input  logic                  vsync_pulse,
    output logic                  fifo_rd_en,
    multichannel_sample_to_pixel_addr_translator_if.master pix,
    output state_t                dbg_state
);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ROW_W   = $clog2(LANE_ROWS);
    localparam int COLUMNS = 32 * WORDS_PER_ROW;
    localparam int COL_W   = $clog2(COLUMNS);

    state_t                    state_q, state_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic [COL_W-1:0]          col_q, col_d;
    logic                      vsync_pending_q, vsync_pending_d;
    logic                      out_valid_q, out_valid_d;
    logic [ADDRESS_LENGTH-1:0] word_address_q, word_address_d;
    logic [4:0]                bit_offset_q, bit_offset_d;
    logic [CH_W-1:0]           channel_q, channel_d;
    logic [ROW_W-1:0]          map_row;
    logic [CH_W-1:0]           map_ch;
    logic                      last_ch;
`ifdef CLIP_DETECT_EN
    logic                      clip_flag_q, clip_flag_d;
    logic                      map_clipped;
`endif

    assign last_ch = (ch_q == CH_W'(NUM_CH - 1));

    // Sample is loaded in CAPTURE, row is ready in ADDR.
    sample_row_mapper #(
        .SAMPLE_BITS (SAMPLE_BITS),
        .LANE_ROWS   (LANE_ROWS),
        .CH_W        (CH_W),
        .ROW_W       (ROW_W)
    ) u_mapper (
        .clk         (clk),
        .reset       (reset),
        .load        (state_q == CAPTURE),
        .sample_in   (fifo_dout[DATA_WIDTH-1 -: SAMPLE_BITS]),
        .ch_in       (ch_q),
        .row_out     (map_row),
`ifdef CLIP_DETECT_EN
        .clipped_out (map_clipped),
`endif
        .ch_out      (map_ch)
    );

    generate
        if (DATA_WIDTH > SAMPLE_BITS) begin : g_low_bits
            // Bits below the left-justified sample carry no information.
            logic unused_low_bits;
            assign unused_low_bits = ^fifo_dout[DATA_WIDTH-SAMPLE_BITS-1:0];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_almost_empty) state_d = READ;
            READ:    state_d = CAPTURE;
            CAPTURE: state_d = SCALE;
            SCALE:   state_d = ADDR;
            ADDR:    state_d = EMIT;
            EMIT:    if (pix.out_ready) state_d = last_ch ? IDLE : READ;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic.
    always_comb begin
        fifo_rd_en      = (state_q == READ);
        ch_d            = ch_q;
        col_d           = col_q;
        // A pulse is remembered in any state until the next column advance.
        vsync_pending_d = vsync_pending_q | vsync_pulse;
        out_valid_d     = out_valid_q;
        word_address_d  = word_address_q;
        bit_offset_d    = bit_offset_q;
        channel_d       = channel_q;
`ifdef CLIP_DETECT_EN
        clip_flag_d     = clip_flag_q;
`endif
        case (state_q)
            IDLE: begin
                ch_d = '0;
            end
            ADDR: begin
                word_address_d = ADDRESS_LENGTH'((32'(map_ch) * 32'(LANE_ROWS) + 32'(map_row))
                                                 * 32'(WORDS_PER_ROW) + 32'(col_q >> 5));
                bit_offset_d   = col_q[4:0];
                channel_d      = map_ch;
                out_valid_d    = 1'b1;
`ifdef CLIP_DETECT_EN
                clip_flag_d    = map_clipped;
`endif
            end
            EMIT: begin
                if (pix.out_ready) begin
                    out_valid_d = 1'b0;
                    if (last_ch) begin
                        ch_d = '0;
                        // A pulse arriving on this very cycle is honoured here.
                        if (vsync_pending_q || vsync_pulse) begin
                            col_d           = '0;
                            vsync_pending_d = 1'b0;
                        end else begin
                            col_d = (col_q == COL_W'(COLUMNS - 1)) ? '0 : col_q + 1'b1;
                        end
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_q            <= '0;
            col_q           <= '0;
            vsync_pending_q <= 1'b0;
            out_valid_q     <= 1'b0;
            word_address_q  <= '0;
            bit_offset_q    <= '0;
            channel_q       <= '0;
`ifdef CLIP_DETECT_EN
            clip_flag_q     <= 1'b0;
`endif
        end else begin
            ch_q            <= ch_d;
            col_q           <= col_d;
            vsync_pending_q <= vsync_pending_d;
            out_valid_q     <= out_valid_d;
            word_address_q  <= word_address_d;
            bit_offset_q    <= bit_offset_d;
            channel_q       <= channel_d;
`ifdef CLIP_DETECT_EN
            clip_flag_q     <= clip_flag_d;
`endif
        end
    end

    assign pix.word_address = word_address_q;
    assign pix.bit_offset   = bit_offset_q;
    assign pix.channel      = channel_q;
    assign pix.out_valid    = out_valid_q;
`ifdef CLIP_DETECT_EN
    assign pix.clip_flag    = clip_flag_q;
`endif
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_multichannel_sample_to_pixel_addr_translator.sv
// ---------------------------------------------------------------------------
// tb_multichannel_sample_to_pixel_addr_translator
// Self-checking bench: a FIFO model feeds frames, a reference model computes
// the expected pixel location of every sample into exp_q, and a monitor
// compares each accepted output against the head of exp_q.
// Optional feature macro honoured: CLIP_DETECT_EN
// ---------------------------------------------------------------------------
module tb_multichannel_sample_to_pixel_addr_translator;
    import viz_pkg::*;

    localparam int DATA_WIDTH     = 32;
    localparam int SAMPLE_BITS    = 24;
    localparam int ADDRESS_LENGTH = 14;
    localparam int NUM_CH         = 2;
    localparam int LANE_ROWS      = 288;
    localparam int WORDS_PER_ROW  = 24;
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int COLUMNS        = 32 * WORDS_PER_ROW;
    localparam int W              = ADDRESS_LENGTH + 5 + CH_W + 1;
    localparam longint FULL_HALF  = longint'(1) << (SAMPLE_BITS - 1);
    localparam longint CLIP_THR   = FULL_HALF - (longint'(1) << (SAMPLE_BITS - 4));

    // ---------------- clock / reset ----------------
    logic                  clk = 1'b0;
    logic                  reset;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_almost_empty;
    logic                  vsync_pulse;
    logic                  fifo_rd_en;
    state_t                dbg_state;

    always #5 clk = ~clk;

    multichannel_sample_to_pixel_addr_translator_if #(
        .ADDRESS_LENGTH(ADDRESS_LENGTH), .CH_W(CH_W)
    ) pix ();

    multichannel_sample_to_pixel_addr_translator #(
        .DATA_WIDTH(DATA_WIDTH), .SAMPLE_BITS(SAMPLE_BITS), .ADDRESS_LENGTH(ADDRESS_LENGTH),
        .NUM_CH(NUM_CH), .LANE_ROWS(LANE_ROWS), .WORDS_PER_ROW(WORDS_PER_ROW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .fifo_dout         (fifo_dout),
        .fifo_almost_empty (fifo_almost_empty),
        .vsync_pulse       (vsync_pulse),
        .fifo_rd_en        (fifo_rd_en),
        .pix               (pix),
        .dbg_state         (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0]          exp_q[$];
    logic [DATA_WIDTH-1:0] fifo_q[$];
    logic [DATA_WIDTH-1:0] frame_w[NUM_CH];
    int n_checks = 0;
    int n_errors = 0;
    int rd_count = 0;
    int col_m    = 0;
    bit pend_m   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference location of one sample.
    function automatic logic [W-1:0] expect_entry(input logic [DATA_WIDTH-1:0] w,
                                                  input int c, input int col);
        logic signed [SAMPLE_BITS-1:0] sv;
        longint s, p, q, r, addr;
        bit clipped;
        sv = w[DATA_WIDTH-1 -: SAMPLE_BITS];
        s  = sv;
        p  = s * (LANE_ROWS / 2);
        if (p >= 0) q = p / FULL_HALF;
        else        q = -((-p + FULL_HALF - 1) / FULL_HALF);
        r = LANE_ROWS / 2 - q;
        clipped = 1'b0;
        if (r < 0) begin
            r = 0; clipped = 1'b1;
        end else if (r > LANE_ROWS - 1) begin
            r = LANE_ROWS - 1; clipped = 1'b1;
        end
        if (s >= CLIP_THR || s <= -CLIP_THR) clipped = 1'b1;
        addr = (c * LANE_ROWS + r) * WORDS_PER_ROW + col / 32;
        return {ADDRESS_LENGTH'(addr), 5'(col % 32), CH_W'(c), clipped};
    endfunction

    // ---------------- FIFO model ----------------
    always @(negedge clk) begin
        if (fifo_rd_en) begin
            rd_count++;
            if (fifo_q.size() == 0) chk("fifo_underflow", 1, 0);
            else fifo_dout = fifo_q.pop_front();
        end
        fifo_almost_empty = (fifo_q.size() < NUM_CH);
    end

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!reset && pix.out_valid && pix.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("word_address", 32'(pix.word_address), 32'(e[W-1 -: ADDRESS_LENGTH]));
                chk("bit_offset", 32'(pix.bit_offset), 32'(e[W-ADDRESS_LENGTH-1 -: 5]));
                chk("channel", 32'(pix.channel), 32'(e[CH_W:1]));
`ifdef CLIP_DETECT_EN
                chk("clip_flag", 32'(pix.clip_flag), 32'(e[0]));
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_frame();
        for (int c = 0; c < NUM_CH; c++) begin
            fifo_q.push_back(frame_w[c]);
            exp_q.push_back(expect_entry(frame_w[c], c, col_m));
        end
        if (pend_m) begin
            col_m  = 0;
            pend_m = 1'b0;
        end else begin
            col_m = (col_m == COLUMNS - 1) ? 0 : col_m + 1;
        end
    endtask

    task automatic set_frame(input logic [DATA_WIDTH-1:0] w0, input logic [DATA_WIDTH-1:0] w1);
        frame_w[0] = w0;
        frame_w[1] = w1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || dbg_state != IDLE || fifo_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n >= 200), 0);
    endtask

    task automatic wait_state(input state_t s, input string tag);
        int n = 0;
        while (dbg_state != s && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n >= 200), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time %0t reached limit %0d", $time, 3000000);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int rd_before, n;
        logic [W-1:0] e;

        reset = 1'b1;
        pix.out_ready = 1'b1;
        vsync_pulse = 1'b0;
        fifo_dout = '0;
        fifo_almost_empty = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_valid", 32'(pix.out_valid), 0);
        chk("rst_addr", 32'(pix.word_address), 0);
        chk("rst_bit", 32'(pix.bit_offset), 0);
        chk("rst_channel", 32'(pix.channel), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Zero frame at column 0: lane centres.
        rd_before = rd_count;
        set_frame(32'h0000_0000, 32'h0000_0000);
        send_frame();
        wait_idle("zero_frame_drain");
        chk("zero_frame_rd_pulses", 32'(rd_count - rd_before), NUM_CH);

        // Near full-scale positive and full-scale negative (clamped).
        set_frame(32'h7FFF_FF00, 32'h8000_0000);
        send_frame();
        wait_idle("extreme_drain");
        set_frame(32'h8000_0000, 32'h7FFF_FF00);
        send_frame();
        wait_idle("extreme2_drain");

        // Consumer stalls for 10 cycles in EMIT.
        @(posedge clk); #1 pix.out_ready = 1'b0;
        set_frame(32'h1234_5600, 32'hFEDC_BA00);
        send_frame();
        n = 0;
        while (!pix.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_wait_valid", 32'(n >= 100), 0);
        rd_before = rd_count;
        e = exp_q[0];
        repeat (10) begin
            @(negedge clk);
            chk("stall_valid", 32'(pix.out_valid), 1);
            chk("stall_addr", 32'(pix.word_address), 32'(e[W-1 -: ADDRESS_LENGTH]));
            chk("stall_bit", 32'(pix.bit_offset), 32'(e[W-ADDRESS_LENGTH-1 -: 5]));
            chk("stall_channel", 32'(pix.channel), 32'(e[CH_W:1]));
            chk("stall_rd_en", 32'(fifo_rd_en), 0);
            chk("stall_rd_count", 32'(rd_count), 32'(rd_before));
        end
        @(posedge clk); #1 pix.out_ready = 1'b1;
        wait_idle("stall_drain");

        // Random samples with a randomly toggling consumer.
        repeat (12) begin
            for (int c = 0; c < NUM_CH; c++) begin
                case ($urandom_range(0, 3))
                    0: frame_w[c] = $urandom;
                    1: frame_w[c] = 32'h7F00_0000 | ($urandom & 32'h00FF_FFFF);
                    2: frame_w[c] = 32'h8000_0000 | ($urandom & 32'h00FF_FFFF);
                    default: frame_w[c] = 32'(int'($urandom_range(0, 32'h0FFF_FFFF)) - 32'h0800_0000);
                endcase
            end
            send_frame();
            n = 0;
            while (!(exp_q.size() == 0 && dbg_state == IDLE) && n < 400) begin
                @(posedge clk); #1 pix.out_ready = 1'($urandom_range(0, 1));
                n++;
            end
            chk("rand_drain", 32'(n >= 400), 0);
            pix.out_ready = 1'b1;
        end

        // Walk to column 100, then VSYNC during ch0 CAPTURE.
        set_frame(32'h0000_0000, 32'h0000_0000);
        while (col_m != 100) begin
            send_frame();
            wait_idle("walk_drain");
        end
        pend_m = 1'b1;
        send_frame();
        wait_state(CAPTURE, "vsync_wait_capture");
        vsync_pulse = 1'b1;
        @(negedge clk);
        vsync_pulse = 1'b0;
        wait_idle("vsync_drain");
        send_frame();
        wait_idle("post_vsync_drain");
        repeat (3) begin
            send_frame();
            wait_idle("walk2_drain");
        end

        // VSYNC on the same cycle as the last-channel acceptance.
        pend_m = 1'b1;
        send_frame();
        n = 0;
        while (!(dbg_state == EMIT && pix.out_valid && pix.channel == CH_W'(NUM_CH - 1)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("late_vsync_wait", 32'(n >= 200), 0);
        vsync_pulse = 1'b1;
        @(negedge clk);
        vsync_pulse = 1'b0;
        wait_idle("late_vsync_drain");
        repeat (2) begin
            send_frame();
            wait_idle("late_vsync_next");
        end

        // Full column sweep including the 767 -> 0 wrap.
        repeat (COLUMNS + 2) begin
            send_frame();
            wait_idle("sweep_drain");
        end

        // Async reset while the last channel is in SCALE.
        set_frame(32'h4000_0000, 32'hC000_0000);
        send_frame();
        n = 0;
        while (!(dbg_state == SCALE && exp_q.size() == NUM_CH - 1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reset_wait_scale", 32'(n >= 200), 0);
        #2 reset = 1'b1;
        #1;
        chk("async_state", 32'(dbg_state), 32'(IDLE));
        chk("async_rd_en", 32'(fifo_rd_en), 0);
        chk("async_valid", 32'(pix.out_valid), 0);
        chk("async_addr", 32'(pix.word_address), 0);
        chk("async_bit", 32'(pix.bit_offset), 0);
        chk("async_channel", 32'(pix.channel), 0);
        exp_q.delete();
        col_m  = 0;
        pend_m = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        set_frame(32'h0000_0000, 32'h0000_0000);
        send_frame();
        wait_idle("restart_drain");

        chk("exp_q_empty", 32'(exp_q.size()), 0);
        chk("fifo_empty", 32'(fifo_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
